driver_conf_scheduler: RTL and testbench

- Sequences configuration writes into driver_controller.
- Issues the default configuration once after reset, then accepts 48-bit configuration words from the host (SPI register block).
- Delivers each word as serialized_conf plus a one-cycle new_configuration_ready pulse, only inside the inter-slice idle window so a slice is never torn.
- Holds the word stable while the driver runs FCWRTEN/WRTFC/READFC, and blocks the host until that sequence completes.

---
 rtl/driver_conf_scheduler.sv | 115 +++++++++++
 tb/tb_driver_conf_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/driver_conf_scheduler.sv
// Configuration write scheduler for driver_controller: issues DEFAULT_CONF after reset,
// then hands host words over only inside the inter-slice idle window.
module driver_conf_scheduler #(
   parameter int                    CONF_WIDTH     = 48,
   parameter logic [CONF_WIDTH-1:0] DEFAULT_CONF   = '0,
   parameter int                    BUSY_CYCLES    = 120,
   parameter int                    WINDOW_TIMEOUT = 4096
) (
   input  logic                  clk_lse,
   input  logic                  rst,
   input  logic [CONF_WIDTH-1:0] host_conf,
   input  logic                  host_conf_valid,
   output logic                  host_conf_ready,
   input  logic                  slice_idle,
   input  logic                  position_sync,
   output logic [CONF_WIDTH-1:0] serialized_conf,
   output logic                  new_configuration_ready,
   output logic                  conf_busy,
   output logic                  conf_overwritten,
   output logic                  conf_forced,
   output logic [7:0]            conf_applied_count
);

   // state   | meaning
   // ST_BOOT | first edge after reset, issue DEFAULT_CONF unconditionally
   // ST_IDLE | accepting host words, waiting for an idle window to issue
   // ST_BUSY | driver running its configuration sequence, word held stable
   typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_BUSY} state_t;

   localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
   localparam int WAIT_W = $clog2(WINDOW_TIMEOUT + 1);
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WINDOW_TIMEOUT - 1);

   state_t                  state;
   logic [BUSY_W-1:0]       busy_cnt;
   logic [WAIT_W-1:0]       wait_cnt;
   logic                    pending;
   logic [CONF_WIDTH-1:0]   pending_word;

   logic accept;
   logic window_open;
   logic force_issue;
   logic issue;

   assign accept      = host_conf_valid && host_conf_ready;
   assign window_open = pending && slice_idle && !position_sync;
   assign force_issue = pending && !window_open && (wait_cnt == WAIT_LAST);
   assign issue       = window_open || force_issue;

   always_ff @(posedge clk_lse or posedge rst) begin
      if (rst) begin
         state                   <= ST_BOOT;
         serialized_conf         <= DEFAULT_CONF;
         new_configuration_ready <= 1'b0;
         host_conf_ready         <= 1'b0;
         conf_busy               <= 1'b1;
         conf_overwritten        <= 1'b0;
         conf_forced             <= 1'b0;
         conf_applied_count      <= 8'd0;
         pending                 <= 1'b0;
         pending_word            <= '0;
         wait_cnt                <= '0;
         busy_cnt                <= '0;
      end else begin
         new_configuration_ready <= 1'b0;
         conf_overwritten        <= 1'b0;
         conf_forced             <= 1'b0;
         case (state)
            ST_BOOT: begin
               new_configuration_ready <= 1'b1;
               conf_applied_count      <= conf_applied_count + 8'd1;
               busy_cnt                <= '0;
               state                   <= ST_BUSY;
            end
            ST_BUSY: begin
               if (busy_cnt == BUSY_LAST) begin
                  busy_cnt        <= '0;
                  host_conf_ready <= 1'b1;
                  conf_busy       <= pending;
                  state           <= ST_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (issue) begin
                  // an accept on the issue edge becomes the next pending word
                  serialized_conf         <= pending_word;
                  new_configuration_ready <= 1'b1;
                  conf_forced             <= force_issue;
                  conf_applied_count      <= conf_applied_count + 8'd1;
                  pending                 <= accept;
                  if (accept) pending_word <= host_conf;
                  wait_cnt                <= '0;
                  busy_cnt                <= '0;
                  host_conf_ready         <= 1'b0;
                  conf_busy               <= 1'b1;
                  state                   <= ST_BUSY;
               end else begin
                  if (accept) begin
                     pending_word     <= host_conf;
                     pending          <= 1'b1;
                     conf_overwritten <= pending;
                  end
                  wait_cnt  <= pending ? wait_cnt + 1'b1 : '0;
                  conf_busy <= pending || accept;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_driver_conf_scheduler.sv
// Scoreboard bench for driver_conf_scheduler: a cycle-level model predicts issue pulses,
// overwrite pulses, ready/busy levels and the held word; a monitor compares.
module tb_driver_conf_scheduler;

   localparam int          BUSY_CYCLES    = 120;
   localparam int          WINDOW_TIMEOUT = 4096;
   localparam logic [47:0] DEFAULT_CONF   = 48'h0;

   logic        clk_lse = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] host_conf = '0;
   logic        host_conf_valid = 1'b0;
   logic        host_conf_ready;
   logic        slice_idle = 1'b0;
   logic        position_sync = 1'b0;
   logic [47:0] serialized_conf;
   logic        new_configuration_ready;
   logic        conf_busy;
   logic        conf_overwritten;
   logic        conf_forced;
   logic [7:0]  conf_applied_count;

   driver_conf_scheduler #(
      .CONF_WIDTH(48), .DEFAULT_CONF(DEFAULT_CONF),
      .BUSY_CYCLES(BUSY_CYCLES), .WINDOW_TIMEOUT(WINDOW_TIMEOUT)
   ) dut (
      .clk_lse(clk_lse), .rst(rst),
      .host_conf(host_conf), .host_conf_valid(host_conf_valid),
      .host_conf_ready(host_conf_ready),
      .slice_idle(slice_idle), .position_sync(position_sync),
      .serialized_conf(serialized_conf),
      .new_configuration_ready(new_configuration_ready),
      .conf_busy(conf_busy), .conf_overwritten(conf_overwritten),
      .conf_forced(conf_forced), .conf_applied_count(conf_applied_count)
   );

   always #5 clk_lse = ~clk_lse;

   typedef struct {
      logic [47:0] word;
      logic        forced;
      logic [7:0]  count;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   ow_q[$];

   int checks = 0;
   int errors = 0;

   // model state, expressed in absolute cycle numbers since reset release
   int          c = 0;
   int          cur_cyc = 0;
   int          m_idle_from = 0;
   int          m_wait_from = 0;
   bit          m_pend = 0;
   logic [47:0] m_word = '0;
   logic [7:0]  m_count = '0;
   logic        exp_ready = 1'b0;
   logic        exp_busy = 1'b1;
   logic [47:0] exp_conf = '0;
   bit          mon_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s cyc %0d got %h expected %h", name, cur_cyc, act, exp_v);
      end
   endtask

   task automatic model_reset();
      exp_t e;
      exp_q.delete();
      ow_q.delete();
      c           = 0;
      m_idle_from = BUSY_CYCLES + 1;
      m_pend      = 0;
      m_count     = 8'd1;
      exp_conf    = DEFAULT_CONF;
      e.word = DEFAULT_CONF; e.forced = 1'b0; e.count = 8'd1; e.cyc = 1;
      exp_q.push_back(e);
   endtask

   // drive one cycle of inputs and advance the model over that cycle
   task automatic step(input logic v, input logic [47:0] w, input logic si, input logic ps);
      bit   idle, win, frc, acc;
      exp_t e;
      host_conf_valid = v;
      host_conf       = w;
      slice_idle      = si;
      position_sync   = ps;
      idle      = (c >= m_idle_from);
      cur_cyc   = c;
      exp_ready = idle;
      exp_busy  = !idle || m_pend;
      acc = v && idle;
      win = si && !ps;
      frc = !win && ((c - m_wait_from) == WINDOW_TIMEOUT - 1);
      if (idle && m_pend && (win || frc)) begin
         m_count = m_count + 8'd1;
         e.word = m_word; e.forced = frc; e.count = m_count; e.cyc = c + 1;
         exp_q.push_back(e);
         m_idle_from = c + 1 + BUSY_CYCLES;
         m_pend = acc;
         if (acc) begin
            m_word      = w;
            m_wait_from = m_idle_from;
         end
      end else if (acc) begin
         if (m_pend) ow_q.push_back(c + 1);
         else m_wait_from = c + 1;
         m_pend = 1;
         m_word = w;
      end
      @(posedge clk_lse);
      #1;
      c++;
   endtask

   always @(negedge clk_lse) begin
      if (mon_en && !rst) begin
         chk("host_conf_ready", 64'(host_conf_ready), 64'(exp_ready));
         chk("conf_busy", 64'(conf_busy), 64'(exp_busy));
         while (exp_q.size() > 0 && exp_q[0].cyc < cur_cyc) begin
            chk("missed_issue_pulse_cycle", 64'(cur_cyc), 64'(exp_q[0].cyc));
            void'(exp_q.pop_front());
         end
         while (ow_q.size() > 0 && ow_q[0] < cur_cyc) begin
            chk("missed_overwrite_pulse_cycle", 64'(cur_cyc), 64'(ow_q[0]));
            void'(ow_q.pop_front());
         end
         if (new_configuration_ready) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cur_cyc) begin
               exp_t e;
               e = exp_q.pop_front();
               exp_conf = e.word;
               chk("issue_word", 64'(serialized_conf), 64'(e.word));
               chk("issue_forced", 64'(conf_forced), 64'(e.forced));
               chk("issue_count", 64'(conf_applied_count), 64'(e.count));
            end else begin
               chk("unexpected_issue_pulse", 64'(new_configuration_ready), 64'(0));
            end
         end else begin
            chk("conf_forced_without_issue", 64'(conf_forced), 64'(0));
         end
         if (conf_overwritten) begin
            if (ow_q.size() > 0 && ow_q[0] == cur_cyc) begin
               chk("overwrite_pulse_cycle", 64'(cur_cyc), 64'(ow_q.pop_front()));
            end else begin
               chk("unexpected_overwrite_pulse", 64'(conf_overwritten), 64'(0));
            end
         end
         chk("serialized_conf_held", 64'(serialized_conf), 64'(exp_conf));
      end
   end

   task automatic chk_reset_values();
      chk("rst_serialized_conf", 64'(serialized_conf), 64'(DEFAULT_CONF));
      chk("rst_new_conf_ready", 64'(new_configuration_ready), 64'(0));
      chk("rst_host_conf_ready", 64'(host_conf_ready), 64'(0));
      chk("rst_conf_busy", 64'(conf_busy), 64'(1));
      chk("rst_conf_overwritten", 64'(conf_overwritten), 64'(0));
      chk("rst_conf_forced", 64'(conf_forced), 64'(0));
      chk("rst_conf_applied_count", 64'(conf_applied_count), 64'(0));
   endtask

   initial begin
      logic [47:0] rw;
      repeat (3) @(posedge clk_lse);
      #1;
      chk_reset_values();

      // boot issue of DEFAULT_CONF with the host idle
      rst = 1'b0;
      model_reset();
      mon_en = 1;
      repeat (125) step(1'b0, '0, 1'b0, 1'b0);

      // single word with the window open
      step(1'b1, 48'h0123_4567_89AB, 1'b1, 1'b0);
      repeat (125) step(1'b0, '0, 1'b1, 1'b0);

      // A then B three cycles later with no window: B replaces A
      step(1'b1, 48'hAAAA_1111_2222, 1'b0, 1'b0);
      repeat (2) step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 48'hBBBB_3333_4444, 1'b0, 1'b0);
      repeat (4) step(1'b0, '0, 1'b0, 1'b0);
      repeat (125) step(1'b0, '0, 1'b1, 1'b0);

      // window coincident with position_sync must not issue
      step(1'b1, 48'hD00D_5555_6666, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      repeat (125) step(1'b0, '0, 1'b0, 1'b0);

      // no window at all: forced issue after the timeout
      step(1'b1, 48'hEEEE_7777_8888, 1'b0, 1'b0);
      repeat (WINDOW_TIMEOUT + 130) step(1'b0, '0, 1'b0, 1'b0);

      // randomized traffic with frequent windows
      for (int i = 0; i < 3000; i++) begin
         rw = {16'($urandom), 32'($urandom)};
         step(($urandom % 8) == 0, rw, ($urandom % 3) != 0, ($urandom % 4) == 0);
      end
      repeat (260) step(1'b0, '0, 1'b1, 1'b0);

      // reset mid-BUSY with word C pending behind an issued word
      step(1'b1, 48'h1357_9BDF_2468, 1'b0, 1'b0);
      step(1'b1, 48'hCCCC_9999_0000, 1'b1, 1'b0);
      repeat (50) step(1'b0, '0, 1'b0, 1'b0);
      mon_en = 0;
      rst = 1'b1;
      #1;
      chk_reset_values();
      repeat (3) @(posedge clk_lse);
      #1;
      rst = 1'b0;
      model_reset();
      mon_en = 1;
      repeat (130) step(1'b0, '0, 1'b1, 1'b0);

      chk("issue_pulses_outstanding", 64'(exp_q.size()), 64'(0));
      chk("overwrite_pulses_outstanding", 64'(ow_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
